// File: rtl/nanosoc_accelerator_ss_xor_engine_if.sv
// nanosoc_accelerator_ss_xor_engine_if: AHB-Lite slave port bundle for the XOR engine
interface nanosoc_accelerator_ss_xor_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL_i;
    logic [ADDR_W-1:0] HADDR_i;
    logic [1:0]        HTRANS_i;
    logic [2:0]        HSIZE_i;
    logic [3:0]        HPROT_i;
    logic              HWRITE_i;
    logic              HREADY_i;
    logic [DATA_W-1:0] HWDATA_i;
    logic              HREADYOUT_o;
    logic [DATA_W-1:0] HRDATA_o;
    logic              HRESP_o;
    modport master (
        output HSEL_i, HADDR_i, HTRANS_i, HSIZE_i, HPROT_i, HWRITE_i, HREADY_i, HWDATA_i,
        input  HREADYOUT_o, HRDATA_o, HRESP_o
    );
    modport slave (
        input  HSEL_i, HADDR_i, HTRANS_i, HSIZE_i, HPROT_i, HWRITE_i, HREADY_i, HWDATA_i,
        output HREADYOUT_o, HRDATA_o, HRESP_o
    );
endinterface

// File: rtl/nanosoc_accelerator_ss_xor_engine.sv
// nanosoc_accelerator_ss_xor_engine: AHB-fed FIFO XOR engine with DMA burst requests and interrupts
module nanosoc_accelerator_ss_xor_engine #(
    parameter int SYS_ADDR_W = 32,
    parameter int SYS_DATA_W = 32,
    parameter int IRQ_NUM    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                                HCLK,
    input  logic                                HRESET,
    nanosoc_accelerator_ss_xor_engine_if.slave  ahb,
    output logic                                exp_drq_ip_o,
    input  logic                                exp_dlast_ip_i,
    output logic                                exp_drq_op_o,
    input  logic                                exp_dlast_op_i,
    output logic [IRQ_NUM-1:0]                  exp_irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] BURST = LW'(BURST_LEN);
    typedef enum logic [1:0] {IDLE, REQ, GAP} drq_t;
    logic                  valid_q, write_q;
    logic [11:0]           addr_q;
    logic                  en_q, en_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [3:0]            irq_en_q, irq_en_d;
    logic [SYS_DATA_W-1:0] key_q, key_d, wcount_q, wcount_d, rdata;
    logic [SYS_DATA_W-1:0] in_mem_q [FIFO_DEPTH];
    logic [SYS_DATA_W-1:0] out_mem_q [FIFO_DEPTH];
    logic [LW-1:0]         in_wp_q, in_wp_d, in_rp_q, in_rp_d, out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [LW-1:0]         in_lvl, out_lvl;
    logic                  in_full, in_empty, out_full, out_empty;
    logic                  wr, rd, in_win, out_win, bus_push, bus_pop, ctrl_wr, key_wr, stat_wr, clr;
    logic                  in_push, out_pop, eng, ip_go, op_go;
    drq_t                  ip_q, ip_d, op_q, op_d;
    logic                  unused_ok;
    assign unused_ok = ^{ahb.HSIZE_i, ahb.HPROT_i, ahb.HADDR_i[SYS_ADDR_W-1:12], ahb.HTRANS_i[0]};
    assign in_lvl    = in_wp_q - in_rp_q;
    assign out_lvl   = out_wp_q - out_rp_q;
    assign in_full   = in_lvl == DEPTH;
    assign in_empty  = in_lvl == '0;
    assign out_full  = out_lvl == DEPTH;
    assign out_empty = out_lvl == '0;
    assign wr        = valid_q & write_q;
    assign rd        = valid_q & ~write_q;
    assign in_win    = addr_q[11:10] == 2'b00;
    assign out_win   = addr_q[11:10] == 2'b01;
    assign bus_push  = wr & in_win;
    assign bus_pop   = rd & out_win;
    assign ctrl_wr   = wr & (addr_q == 12'h800);
    assign key_wr    = wr & (addr_q == 12'h808);
    assign stat_wr   = wr & (addr_q == 12'h80C);
    assign clr       = ctrl_wr & ahb.HWDATA_i[1];
    assign in_push   = bus_push & ~in_full;
    assign out_pop   = bus_pop & ~out_empty;
    assign eng       = en_q & ~in_empty & ~out_full;
    assign ip_go     = en_q & ((DEPTH - in_lvl) >= BURST);
    assign op_go     = en_q & (out_lvl >= BURST);
    // Address phase is captured here; the write/read it describes acts one cycle later.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else if (ahb.HREADY_i) begin
            valid_q <= ahb.HSEL_i & ahb.HTRANS_i[1];
            write_q <= ahb.HWRITE_i;
            addr_q  <= ahb.HADDR_i[11:0];
        end
    end
    always_comb begin
        en_d     = ctrl_wr ? ahb.HWDATA_i[0] : en_q;
        irq_en_d = ctrl_wr ? ahb.HWDATA_i[7:4] : irq_en_q;
        key_d    = key_wr ? ahb.HWDATA_i : key_q;
        ovf_d    = (bus_push & in_full) | (ovf_q & ~(stat_wr & ahb.HWDATA_i[2]));
        unf_d    = (bus_pop & out_empty) | (unf_q & ~(stat_wr & ahb.HWDATA_i[3]));
        wcount_d = clr ? '0 : wcount_q + SYS_DATA_W'(eng);
        in_wp_d  = clr ? '0 : in_wp_q + LW'(in_push);
        in_rp_d  = clr ? '0 : in_rp_q + LW'(eng);
        out_wp_d = clr ? '0 : out_wp_q + LW'(eng);
        out_rp_d = clr ? '0 : out_rp_q + LW'(out_pop);
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            en_q     <= 1'b0;
            irq_en_q <= '0;
            key_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            wcount_q <= '0;
            in_wp_q  <= '0;
            in_rp_q  <= '0;
            out_wp_q <= '0;
            out_rp_q <= '0;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            key_q    <= key_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            wcount_q <= wcount_d;
            in_wp_q  <= in_wp_d;
            in_rp_q  <= in_rp_d;
            out_wp_q <= out_wp_d;
            out_rp_q <= out_rp_d;
        end
    end
    always_ff @(posedge HCLK) begin
        if (in_push) in_mem_q[in_wp_q[PW-1:0]] <= ahb.HWDATA_i;
        if (eng) out_mem_q[out_wp_q[PW-1:0]] <= in_mem_q[in_rp_q[PW-1:0]] ^ key_q;
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ip_q <= IDLE;
            op_q <= IDLE;
        end else begin
            ip_q <= ip_d;
            op_q <= op_d;
        end
    end
    always_comb begin
        ip_d = (~en_q | clr) ? IDLE :
               ip_q == IDLE  ? (ip_go ? REQ : IDLE) :
               ip_q == REQ   ? ((exp_dlast_ip_i & ahb.HREADY_i) ? GAP : REQ) : IDLE;
        op_d = (~en_q | clr) ? IDLE :
               op_q == IDLE  ? (op_go ? REQ : IDLE) :
               op_q == REQ   ? ((exp_dlast_op_i & ahb.HREADY_i) ? GAP : REQ) : IDLE;
    end
    // Request is raised already in IDLE once the burst fits, so GAP is the only low cycle between bursts.
    always_comb begin
        exp_drq_ip_o = (ip_q == REQ) | ((ip_q == IDLE) & ip_go & ~clr);
        exp_drq_op_o = (op_q == REQ) | ((op_q == IDLE) & op_go & ~clr);
    end
    assign exp_irq_o = irq_en_q & {unf_q, ovf_q, en_q & in_empty & out_empty, out_lvl >= BURST};
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (out_win) rdata = out_empty ? '0 : out_mem_q[out_rp_q[PW-1:0]];
            else case (addr_q)
                12'h800: rdata[7:0] = {irq_en_q, 3'b000, en_q};
                12'h804: begin
                    rdata[LW-1:0]   = in_lvl;
                    rdata[8 +: LW]  = out_lvl;
                    rdata[16]       = in_full;
                    rdata[17]       = out_empty;
                end
                12'h808: rdata = key_q;
                12'h80C: rdata[3:2] = {unf_q, ovf_q};
                12'h810: rdata = wcount_q;
                default: rdata = '0;
            endcase
        end
    end
    assign ahb.HRDATA_o    = rdata;
    assign ahb.HREADYOUT_o = 1'b1;
    assign ahb.HRESP_o     = 1'b0;
endmodule
